// File: rtl/spi_cmd_sequencer.sv
// Walks a command table in an external synchronous ROM and hands each entry to the SPI master.
// Optional macro SPI_SEQ_BITREV_EN: reverse the bit order inside each command byte for an LSB-first master.
module spi_cmd_sequencer #(
    parameter int CMD_WIDTH     = 16,
    parameter int NUM_SS        = 10,
    parameter int NUM_COMMANDS  = 64,
    parameter int ADDR_WIDTH    = 6,
    parameter int STARTUP_DELAY = 1000,
    parameter int GAP_CYCLES    = 10
) (
    input  logic                          clock,
    input  logic                          reset_n,
    output logic [ADDR_WIDTH-1:0]         table_addr,
    input  logic [CMD_WIDTH+NUM_SS+2:0]   table_data,
    input  logic                          start,
    input  logic                          ready,
    output logic [CMD_WIDTH-1:0]          command,
    output logic [NUM_SS-1:0]             ss,
    output logic                          cpol,
    output logic                          cpha,
    output logic                          trigger,
    output logic                          busy,
    output logic                          done
);

    // state        | meaning
    // S_STARTUP    | post-reset delay before the first fetch
    // S_FETCH      | ROM address presented, data arrives next cycle
    // S_LOAD       | capture ROM word into the output registers
    // S_WAIT_READY | hold until the SPI master reports ready
    // S_TRIG       | one-cycle trigger pulse, arm the gap counter
    // S_GAP        | hold-off after trigger; advance or finish at terminal count
    // S_DONE       | table complete, waiting for a start pulse
    typedef enum logic [2:0] {
        S_STARTUP, S_FETCH, S_LOAD, S_WAIT_READY, S_TRIG, S_GAP, S_DONE
    } state_t;

    localparam int CNT_MAX = (STARTUP_DELAY > GAP_CYCLES) ? STARTUP_DELAY : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_COMMANDS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CMD_WIDTH-1:0]    cmd_q, cmd_d;
    logic [NUM_SS-1:0]       ss_q, ss_d;
    logic                    cpol_q, cpol_d;
    logic                    cpha_q, cpha_d;
    logic                    last_q, last_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_STARTUP;
            idx_q   <= '0;
            cnt_q   <= CNT_W'(STARTUP_DELAY);
            cmd_q   <= '0;
            ss_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            ss_q    <= ss_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        ss_d    = ss_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        last_d  = last_q;
        case (state_q)
            S_STARTUP: begin
                // Terminal count is reached on the transition itself, so FETCH follows the last decrement.
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                cmd_d   = table_data[CMD_WIDTH-1:0];
                ss_d    = table_data[CMD_WIDTH +: NUM_SS];
                cpol_d  = table_data[CMD_WIDTH+NUM_SS];
                cpha_d  = table_data[CMD_WIDTH+NUM_SS+1];
                last_d  = table_data[CMD_WIDTH+NUM_SS+2];
                state_d = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (ready) state_d = S_TRIG;
            end
            S_TRIG: begin
                cnt_d   = CNT_W'(GAP_CYCLES);
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q <= CNT_ONE) begin
                    cnt_d = '0;
                    if (last_q || (idx_q == LAST_IDX)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_STARTUP;
        endcase
    end

`ifdef SPI_SEQ_BITREV_EN
    always_comb begin
        command = '0;
        for (int b = 0; b < CMD_WIDTH / 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                command[8*b + i] = cmd_q[8*b + 7 - i];
            end
        end
    end
`else
    assign command = cmd_q;
`endif

    assign table_addr = idx_q;
    assign ss         = ss_q;
    assign cpol       = cpol_q;
    assign cpha       = cpha_q;
    assign trigger    = (state_q == S_TRIG);
    assign busy       = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: 4-entry table, short startup delay and gap.
module tb_spi_cmd_sequencer;

    localparam int CW = 16;
    localparam int NS = 10;
    localparam int DW = CW + NS + 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    table_addr;
    logic [DW-1:0] table_data;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic [CW-1:0] command;
    logic [NS-1:0] ss;
    logic          cpol, cpha, trigger, busy, done;

    logic [DW-1:0] rom [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int max_addr = 0;
    int trig_cyc[$];
    logic [CW-1:0] trig_cmd[$];

    typedef struct {
        int            cyc;
        logic [CW-1:0] cmd;
        logic [NS-1:0] ss;
        logic          cpol;
        logic          cpha;
    } trig_t;
    trig_t exp_tab[4];

    spi_cmd_sequencer #(
        .CMD_WIDTH(CW), .NUM_SS(NS), .NUM_COMMANDS(4), .ADDR_WIDTH(2),
        .STARTUP_DELAY(8), .GAP_CYCLES(3)
    ) dut (
        .clock(clock), .reset_n(reset_n), .table_addr(table_addr), .table_data(table_data),
        .start(start), .ready(ready), .command(command), .ss(ss), .cpol(cpol), .cpha(cpha),
        .trigger(trigger), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) table_data <= rom[table_addr];

    function automatic logic [CW-1:0] exp_cmd(input logic [CW-1:0] w);
        logic [CW-1:0] r;
        r = w;
`ifdef SPI_SEQ_BITREV_EN
        for (int b = 0; b < CW / 8; b++)
            for (int i = 0; i < 8; i++)
                r[8*b + i] = w[8*b + 7 - i];
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (int'(table_addr) > max_addr) max_addr = int'(table_addr);
        if (trigger) begin
            trig_cyc.push_back(cyc);
            trig_cmd.push_back(command);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_command", 32'(command), 32'h0);
        chk("rst_ss", 32'(ss), 32'h0);
        chk("rst_cpol", 32'(cpol), 32'h0);
        chk("rst_cpha", 32'(cpha), 32'h0);
        chk("rst_trigger", 32'(trigger), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_addr", 32'(table_addr), 32'h0);
    endtask

    task automatic release_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n  = 1'b1;
        cyc      = 0;
        max_addr = 0;
        trig_cyc.delete();
        trig_cmd.delete();
    endtask

    task automatic init_rom();
        rom[0] = {1'b0, 1'b0, 1'b1, 10'b10, 16'h6400};
        rom[1] = {1'b0, 1'b1, 1'b0, 10'b10, 16'h3B01};
        rom[2] = {1'b0, 1'b0, 1'b0, 10'b10, 16'h7802};
        rom[3] = {1'b0, 1'b0, 1'b0, 10'b10, 16'h4403};
    endtask

    initial begin
        exp_tab[0] = '{cyc: 11, cmd: 16'h6400, ss: 10'b10, cpol: 1'b1, cpha: 1'b0};
        exp_tab[1] = '{cyc: 18, cmd: 16'h3B01, ss: 10'b10, cpol: 1'b0, cpha: 1'b1};
        exp_tab[2] = '{cyc: 25, cmd: 16'h7802, ss: 10'b10, cpol: 1'b0, cpha: 1'b0};
        exp_tab[3] = '{cyc: 32, cmd: 16'h4403, ss: 10'b10, cpol: 1'b0, cpha: 1'b0};

        // Full walk with ready tied high
        init_rom();
        ready = 1'b1;
        @(negedge clock);
        check_reset_outputs();
        release_reset();
        for (int c = 1; c <= 36; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (cyc >= exp_tab[i].cyc - 1 && cyc <= exp_tab[i].cyc + 3) begin
                    chk("hold_cmd", 32'(command), 32'(exp_cmd(exp_tab[i].cmd)));
                    chk("hold_ss", 32'(ss), 32'(exp_tab[i].ss));
                    chk("hold_cpol", 32'(cpol), 32'(exp_tab[i].cpol));
                    chk("hold_cpha", 32'(cpha), 32'(exp_tab[i].cpha));
                end
            end
            if (cyc == 35) begin
                chk("done_early", 32'(done), 32'h0);
                chk("busy_early", 32'(busy), 32'h1);
            end
        end
        chk("done_end", 32'(done), 32'h1);
        chk("busy_end", 32'(busy), 32'h0);
        chk("trig_count", 32'(trig_cyc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < trig_cyc.size()) begin
                chk("trig_cycle", 32'(trig_cyc[i]), 32'(exp_tab[i].cyc));
                chk("trig_cmd", 32'(trig_cmd[i]), 32'(exp_cmd(exp_tab[i].cmd)));
            end
        end
        repeat (5) tick();
        chk("done_held", 32'(done), 32'h1);
        chk("cmd_kept", 32'(command), 32'(exp_cmd(16'h4403)));

        // Last flag on entry 1
        rom[1][DW-1] = 1'b1;
        release_reset();
        repeat (40) tick();
        chk("last_trig_count", 32'(trig_cyc.size()), 32'd2);
        chk("last_max_addr", 32'(max_addr), 32'd1);
        chk("last_done", 32'(done), 32'h1);
        if (trig_cyc.size() == 2) chk("last_trig2_cyc", 32'(trig_cyc[1]), 32'd18);
        init_rom();

        // ready held low in WAIT_READY
        ready = 1'b0;
        release_reset();
        repeat (30) tick();
        chk("wait_no_trig", 32'(trig_cyc.size()), 32'd0);
        chk("wait_cmd", 32'(command), 32'(exp_cmd(16'h6400)));
        chk("wait_cpol", 32'(cpol), 32'h1);
        chk("wait_busy", 32'(busy), 32'h1);
        ready = 1'b1;
        tick();
        chk("wait_trig_rise", 32'(trigger), 32'h1);
        tick();
        chk("wait_trig_fall", 32'(trigger), 32'h0);

        // Reset during entry 2 gap, busy start ignored, replay from DONE
        release_reset();
        while (cyc < 26) tick();
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        release_reset();
        while (cyc < 5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < 36) tick();
        chk("rerun_trig_count", 32'(trig_cyc.size()), 32'd4);
        if (trig_cyc.size() > 0) chk("rerun_first_trig", 32'(trig_cyc[0]), 32'd11);
        chk("rerun_done", 32'(done), 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("replay_busy", 32'(busy), 32'h1);
        chk("replay_done", 32'(done), 32'h0);
        chk("replay_addr", 32'(table_addr), 32'h0);
        tick();
        tick();
        chk("replay_pre_trig", 32'(trigger), 32'h0);
        tick();
        chk("replay_trig", 32'(trigger), 32'h1);
        chk("replay_cmd", 32'(command), 32'(exp_cmd(16'h6400)));

        // Byte-wise bit reversal option
        rom[0] = {1'b1, 1'b0, 1'b0, 10'b1, 16'h0102};
        release_reset();
        while (cyc < 11) tick();
        chk("bitrev_trig", 32'(trigger), 32'h1);
`ifdef SPI_SEQ_BITREV_EN
        chk("bitrev_cmd", 32'(command), 32'h8040);
`else
        chk("bitrev_cmd", 32'(command), 32'h0102);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
